reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Parametrised register scoreboard for the decode stage. It generalises the single-stage load-use block test into per-register pending-write tracking across any pipeline depth.
- For every architectural register it counts writes that have issued but not yet written back, and reports busy status on NUM_RD read ports.
- Sits beside decode. Decode issues into it, writeback retires from it, and the exception/flush path clears it.

Parameters:
NUM_REGS, 32, architectural register count; register 0 is hard-wired zero.
AW, 5, register address width; clog2(NUM_REGS).
NUM_RD, 2, number of source lookup ports.
CNT_W, 2, per-register outstanding-write counter width; max 2^CNT_W-1 in flight per register.
WB_BYPASS, 1, 1 = a same-cycle writeback to a register clears its busy on lookup; 0 = registered view only.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
issue_valid  in  1  decode issues an instruction this cycle (ds_to_es fire)
issue_gr_we  in  1  issued instruction writes a GPR
issue_dest  in  AW  destination register of issued instruction
issue_ready  out  1  scoreboard can accept the issue (dest counter not saturated)
wb_valid  in  1  writeback stage retires a GPR write this cycle
wb_dest  in  AW  register being written back
flush  in  1  clear all pending state (exception/ertn redirect)
rd_addr  in  NUM_RD*AW  source register addresses, port i at [i*AW +: AW]
rd_busy  out  NUM_RD  port i source has an outstanding write
any_busy  out  1  at least one register pending
total_pending  out  AW+CNT_W  sum of all counters
sb_err  out  1  sticky: a writeback arrived for a register with zero count

Behaviour:
- Reset, asynchronous: all counters = 0 and sb_err = 0. Outputs then read rd_busy=0, any_busy=0, total_pending=0, issue_ready=1.
- Effective issue (inc):
  - inc = issue_valid & issue_gr_we & issue_ready & (issue_dest != 0).
  - An issue with issue_ready=0 is ignored; the producer must hold it.
- Effective writeback (dec): dec = wb_valid & (wb_dest != 0) & (cnt[wb_dest] != 0).
- Counter update per register r, on the clk edge:
  - inc only: +1.
  - dec only: -1.
  - Both inc and dec on r in the same cycle: unchanged.
  - Different registers: both updates apply independently.
- issue_ready: combinational. It is 0 only when cnt[issue_dest] == max and there is no same-cycle dec on issue_dest; otherwise 1. It is always 1 for dest 0 and when issue_gr_we=0.
- Underflow: wb_valid with wb_dest != 0 and cnt[wb_dest] == 0 leaves the counter at 0 and sets sb_err on the next edge. sb_err is cleared only by reset.
- flush:
  - Synchronous; all counters go to 0 at the next edge.
  - It overrides any inc or dec in the same cycle.
  - A writeback in the flush cycle does not set sb_err.
  - sb_err is not cleared by flush.
- rd_busy[i]: combinational from registered counters.
  - busy = (rd_addr_i != 0) & (cnt != 0).
  - With WB_BYPASS=1, busy is additionally forced to 0 when wb_valid & wb_dest == rd_addr_i & cnt == 1.
  - A same-cycle issue never affects rd_busy; an issue at cycle t shows busy from t+1.
- any_busy and total_pending come from registered counters only, with no bypass.
- Register 0: its counter is never instantiated and reads as 0.
- Latency: 1 cycle from issue to busy; 0 cycles from writeback to not-busy when WB_BYPASS=1, otherwise 1 cycle.

Decomposition:
- Shared package (mycpu.h): AW, NUM_REGS and the scoreboard bus widths. These are used by the id stage to pack issue and lookup fields.
- Sub-module sb_counter: one CNT_W saturating up/down counter with inc, dec, clr inputs and cnt, max, zero outputs.
  - It is generated for registers 1..NUM_REGS-1.
  - The top level handles decode, lookup muxing, bypass, the reduction for total_pending, and sb_err.

Test Plan:
- Reset, then issue dest=5 at cycle 1 and lookup rd_addr0=5 in the same cycle -> rd_busy0=0 at cycle 1 and 1 at cycle 2; total_pending=1.
- Issue dest=7 three times with CNT_W=2, then a fourth issue -> issue_ready=0 and cnt stays 3. Fourth issue with wb_dest=7 in the same cycle -> issue_ready=1 and cnt stays 3.
- cnt[9]=1; wb_valid wb_dest=9 with lookup 9 in the same cycle -> rd_busy=0 (WB_BYPASS=1), or 1 with WB_BYPASS=0. Next cycle rd_busy=0 in both cases.
- Issue dest=0 and lookup 0 -> issue_ready=1, rd_busy=0, total_pending unchanged.
- Pending on registers 3, 4, 4; assert flush together with issue dest=3 -> next cycle all counters 0, any_busy=0, total_pending=0.
- wb_valid wb_dest=12 with cnt=0 -> sb_err=1 next cycle; it stays 1 across flush and clears only on asynchronous reset mid-cycle.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Purpose: shared sizing for the decode-stage register scoreboard.
// Latency: n/a (constants only).
// Backpressure: n/a.
// The id stage uses these widths to pack the issue and lookup fields it
// hands to reg_scoreboard.
package reg_scoreboard_pkg;

    localparam int SB_NUM_REGS = 32;                  // architectural GPRs, r0 hard-wired zero
    localparam int SB_AW       = 5;                   // register address width
    localparam int SB_NUM_RD   = 2;                   // source lookup ports
    localparam int SB_CNT_W    = 2;                   // per-register in-flight write counter
    localparam int SB_TOT_W    = SB_AW + SB_CNT_W;    // width of the summed pending count
    localparam int SB_RD_W     = SB_NUM_RD * SB_AW;   // packed lookup address bus width

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// Purpose: one saturating up/down counter of outstanding writes for a single register.
// Latency: cnt updates on the clock edge after inc/dec/clr.
// Backpressure: none here; inc at max or dec at zero is held, the parent gates issue with max.
// Ports: clk/reset (async active-high), inc/dec/clr strobes, cnt value, max/zero flags.
module reg_scoreboard_sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             max,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    assign max  = &cnt_q;
    assign zero = ~|cnt_q;
    assign cnt  = cnt_q;

    // clr wins over everything; a simultaneous inc and dec cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec && !max) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && !inc && !zero) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Purpose: per-register pending-write scoreboard beside decode; reports source busy status.
// Latency: issue -> busy 1 cycle; writeback -> not-busy 0 cycles (WB_BYPASS=1) or 1 cycle.
// Backpressure: issue_ready drops when the destination counter is saturated; producer holds.
// Ports: issue_* from decode, wb_* from writeback, flush from redirect, rd_addr/rd_busy
//        lookup ports, any_busy/total_pending summary, sb_err sticky underflow flag.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NUM_REGS  = SB_NUM_REGS,
    parameter int AW        = SB_AW,
    parameter int NUM_RD    = SB_NUM_RD,
    parameter int CNT_W     = SB_CNT_W,
    parameter int WB_BYPASS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic                 issue_gr_we,
    input  logic [AW-1:0]        issue_dest,
    output logic                 issue_ready,
    input  logic                 wb_valid,
    input  logic [AW-1:0]        wb_dest,
    input  logic                 flush,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD-1:0]    rd_busy,
    output logic                 any_busy,
    output logic [AW+CNT_W-1:0]  total_pending,
    output logic                 sb_err
);

    localparam int TOT_W = AW + CNT_W;

    logic [CNT_W-1:0]    cnt_arr [NUM_REGS];
    logic [NUM_REGS-1:0] max_vec;
    logic [NUM_REGS-1:0] zero_vec;

    logic issue_nz;
    logic wb_nz;
    logic dec_any;
    logic dec_hits_issue;
    logic inc_any;
    logic sb_err_d;
    logic sb_err_q;

    // r0 never gets a counter: it is permanently idle.
    assign cnt_arr[0]  = '0;
    assign max_vec[0]  = 1'b0;
    assign zero_vec[0] = 1'b1;

    assign issue_nz       = (issue_dest != '0);
    assign wb_nz          = (wb_dest != '0);
    assign dec_any        = wb_valid & wb_nz & ~zero_vec[wb_dest];
    assign dec_hits_issue = dec_any & (wb_dest == issue_dest);

    // A saturated destination can still accept an issue if it retires one this cycle.
    assign issue_ready = ~(issue_gr_we & issue_nz & max_vec[issue_dest] & ~dec_hits_issue);
    assign inc_any     = issue_valid & issue_gr_we & issue_ready & issue_nz;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        reg_scoreboard_sb_counter #(
            .CNT_W (CNT_W)
        ) u_sb_counter (
            .clk   (clk),
            .reset (reset),
            .inc   (inc_any && (issue_dest == AW'(r))),
            .dec   (dec_any && (wb_dest == AW'(r))),
            .clr   (flush),
            .cnt   (cnt_arr[r]),
            .max   (max_vec[r]),
            .zero  (zero_vec[r])
        );
    end

    // Lookups see registered counters; the bypass only hides the last outstanding
    // write when it is retiring right now.
    always_comb begin
        logic [AW-1:0] lk_addr;
        rd_busy = '0;
        lk_addr = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            lk_addr    = rd_addr[i*AW +: AW];
            rd_busy[i] = (lk_addr != '0) & ~zero_vec[lk_addr];
            if ((WB_BYPASS != 0) && wb_valid && (wb_dest == lk_addr)
                && (cnt_arr[lk_addr] == CNT_W'(1))) begin
                rd_busy[i] = 1'b0;
            end
        end
    end

    always_comb begin
        total_pending = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            total_pending = total_pending + TOT_W'(cnt_arr[r]);
        end
    end

    assign any_busy = ~&zero_vec;

    // Underflow is sticky until reset; a flush cycle masks it since the writeback
    // belongs to the discarded context.
    assign sb_err_d = sb_err_q | (wb_valid & wb_nz & zero_vec[wb_dest] & ~flush);
    assign sb_err   = sb_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_err_q <= 1'b0;
        end else begin
            sb_err_q <= sb_err_d;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Purpose: directed plus randomized check of reg_scoreboard against a counting model.
// Latency: n/a.
// Backpressure: n/a.
module tb_reg_scoreboard;

    localparam int AW     = 5;
    localparam int NR     = 32;
    localparam int MAXCNT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic        issue_gr_we;
    logic [4:0]  issue_dest;
    logic        issue_ready;
    logic        wb_valid;
    logic [4:0]  wb_dest;
    logic        flush;
    logic [9:0]  rd_addr;
    logic [1:0]  rd_busy;
    logic        any_busy;
    logic [6:0]  total_pending;
    logic        sb_err;

    int m_cnt [NR];
    int m_nxt [NR];
    bit m_err;
    bit m_err_nxt;
    int total_cnt = 0;
    int bad_cnt   = 0;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk           (clk),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_gr_we   (issue_gr_we),
        .issue_dest    (issue_dest),
        .issue_ready   (issue_ready),
        .wb_valid      (wb_valid),
        .wb_dest       (wb_dest),
        .flush         (flush),
        .rd_addr       (rd_addr),
        .rd_busy       (rd_busy),
        .any_busy      (any_busy),
        .total_pending (total_pending),
        .sb_err        (sb_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) else begin
            bad_cnt++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        issue_gr_we = 1'b0;
        issue_dest  = '0;
        wb_valid    = 1'b0;
        wb_dest     = '0;
        flush       = 1'b0;
        rd_addr     = '0;
    endtask

    task automatic model_clear();
        for (int r = 0; r < NR; r++) m_cnt[r] = 0;
        m_err = 1'b0;
    endtask

    function automatic bit m_wb_retires();
        return wb_valid && (wb_dest != 0) && (m_cnt[wb_dest] != 0);
    endfunction

    function automatic bit m_ready();
        if (!issue_gr_we || issue_dest == 0) return 1'b1;
        if (m_cnt[issue_dest] < MAXCNT) return 1'b1;
        return m_wb_retires() && (wb_dest == issue_dest);
    endfunction

    function automatic bit m_busy(input int a);
        if (a == 0 || m_cnt[a] == 0) return 1'b0;
        if (wb_valid && wb_dest == a && m_cnt[a] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int m_total();
        int s = 0;
        foreach (m_cnt[r]) s += m_cnt[r];
        return s;
    endfunction

    // One clock with the currently driven inputs: check every output against the
    // model at the falling edge, then advance the model across the rising edge.
    task automatic run_cycle(input string tag);
        @(negedge clk);
        chk({tag, ".ready"}, 32'(issue_ready), 32'(m_ready()));
        chk({tag, ".busy0"}, 32'(rd_busy[0]), 32'(m_busy(int'(rd_addr[4:0]))));
        chk({tag, ".busy1"}, 32'(rd_busy[1]), 32'(m_busy(int'(rd_addr[9:5]))));
        chk({tag, ".total"}, 32'(total_pending), 32'(m_total()));
        chk({tag, ".any"}, 32'(any_busy), 32'(m_total() != 0));
        chk({tag, ".err"}, 32'(sb_err), 32'(m_err));
        m_nxt     = m_cnt;
        m_err_nxt = m_err;
        if (flush) begin
            foreach (m_nxt[r]) m_nxt[r] = 0;
        end else begin
            if (issue_valid && m_ready() && issue_gr_we && issue_dest != 0)
                m_nxt[issue_dest]++;
            if (m_wb_retires())
                m_nxt[wb_dest]--;
            if (wb_valid && wb_dest != 0 && m_cnt[wb_dest] == 0)
                m_err_nxt = 1'b1;
        end
        @(posedge clk);
        #1;
        m_cnt = m_nxt;
        m_err = m_err_nxt;
        idle();
    endtask

    task automatic do_issue(input int d);
        issue_valid = 1'b1;
        issue_gr_we = 1'b1;
        issue_dest  = 5'(d);
    endtask

    initial begin
        idle();
        model_clear();
        reset = 1'b1;
        #12;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst.busy", 32'(rd_busy), 0);
        chk("rst.any", 32'(any_busy), 0);
        chk("rst.total", 32'(total_pending), 0);
        chk("rst.ready", 32'(issue_ready), 1);
        chk("rst.err", 32'(sb_err), 0);
        @(posedge clk);
        #1;

        // Issue to r5 with same-cycle lookup: busy only from the next cycle
        do_issue(5);
        rd_addr[4:0] = 5'd5;
        #1;
        chk("t1.busy5", 32'(rd_busy[0]), 0);
        run_cycle("t1");
        rd_addr[4:0] = 5'd5;
        #1;
        chk("t2.busy5", 32'(rd_busy[0]), 1);
        chk("t2.total", 32'(total_pending), 1);

        // Saturate r7, then retry with and without a same-cycle writeback
        for (int k = 0; k < 3; k++) begin
            do_issue(7);
            run_cycle("sat");
        end
        do_issue(7);
        #1;
        chk("sat.ready0", 32'(issue_ready), 0);
        run_cycle("sat4");
        chk("sat4.total", 32'(total_pending), 4);
        do_issue(7);
        wb_valid = 1'b1;
        wb_dest  = 5'd7;
        #1;
        chk("sat.ready_wb", 32'(issue_ready), 1);
        run_cycle("satwb");
        chk("satwb.total", 32'(total_pending), 4);

        // Writeback bypass on r9
        do_issue(9);
        run_cycle("r9");
        wb_valid     = 1'b1;
        wb_dest      = 5'd9;
        rd_addr[4:0] = 5'd9;
        #1;
        chk("byp.busy9", 32'(rd_busy[0]), 0);
        run_cycle("byp");
        rd_addr[4:0] = 5'd9;
        #1;
        chk("byp.after", 32'(rd_busy[0]), 0);
        chk("byp.total", 32'(total_pending), 4);

        // Register 0 is never tracked
        do_issue(0);
        rd_addr[9:5] = 5'd0;
        #1;
        chk("r0.ready", 32'(issue_ready), 1);
        chk("r0.busy", 32'(rd_busy[1]), 0);
        run_cycle("r0");
        chk("r0.total", 32'(total_pending), 4);

        // Flush overrides a same-cycle issue
        do_issue(3); run_cycle("p3");
        do_issue(4); run_cycle("p4a");
        do_issue(4); run_cycle("p4b");
        do_issue(3);
        flush = 1'b1;
        run_cycle("flush");
        chk("flush.total", 32'(total_pending), 0);
        chk("flush.any", 32'(any_busy), 0);

        // Underflow: sticky across flush, cleared by a mid-cycle async reset
        wb_valid = 1'b1;
        wb_dest  = 5'd12;
        run_cycle("uf");
        chk("uf.err", 32'(sb_err), 1);
        flush = 1'b1;
        run_cycle("uf_flush");
        chk("uf_flush.err", 32'(sb_err), 1);
        do_issue(6);
        run_cycle("pre_rst");
        #3;
        reset = 1'b1;
        #1;
        chk("arst.err", 32'(sb_err), 0);
        chk("arst.total", 32'(total_pending), 0);
        #2;
        reset = 1'b0;
        model_clear();
        @(posedge clk);
        #1;

        // Randomized traffic over a few registers so counters saturate and collide
        for (int n = 0; n < 600; n++) begin
            issue_valid  = ($urandom_range(0, 3) != 0);
            issue_gr_we  = ($urandom_range(0, 7) != 0);
            issue_dest   = 5'($urandom_range(0, 7));
            wb_valid     = ($urandom_range(0, 1) != 0);
            wb_dest      = 5'($urandom_range(0, 7));
            flush        = ($urandom_range(0, 49) == 0);
            rd_addr[4:0] = 5'($urandom_range(0, 7));
            rd_addr[9:5] = 5'($urandom_range(0, 7));
            run_cycle("rnd");
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
